// File: rtl/fmc_spi_master.sv
// SPI master for FMC-attached converters: one shared SCLK/MOSI, per-slave chip
// select and MISO. Frames are [R/W] + address + data, all MSB-first.
module fmc_spi_master #(
  parameter int g_num_cs     = 4,
  parameter int g_addr_width = 8,
  parameter int g_data_width = 8,
  parameter int g_clk_div    = 2,
  parameter int g_rw_bit     = 1
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    rw_i,
  input  logic [2:0]              cs_sel_i,
  input  logic [g_addr_width-1:0] addr_i,
  input  logic [g_data_width-1:0] data_i,
  output logic [g_data_width-1:0] data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    spi_sclk_o,
  output logic                    spi_sdata_o,
  output logic [g_num_cs-1:0]     spi_n_cs_o,
  input  logic [g_num_cs-1:0]     spi_sdo_i
);

  localparam int c_frame_len = g_rw_bit + g_addr_width + g_data_width;
  localparam int c_cnt_w     = (g_clk_div > 1) ? $clog2(g_clk_div) : 1;
  localparam int c_bit_w     = $clog2(c_frame_len);
  localparam logic [c_cnt_w-1:0] c_div_max = c_cnt_w'(g_clk_div - 1);
  localparam logic [c_bit_w-1:0] c_bit_max = c_bit_w'(c_frame_len - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [c_cnt_w-1:0]      div_cnt;
  logic [c_bit_w-1:0]      bit_cnt;
  logic                    phase_q;
  logic                    rw_q;
  logic [g_num_cs-1:0]     cs_oh_q;
  logic [c_frame_len-1:0]  tx_sr;
  logic [c_frame_len-1:0]  frame_d;
  logic [g_data_width-1:0] rx_sr;

  logic cs_valid;
  logic half_end;
  logic last_bit;
  logic sample;
  logic sdo_bit;
  logic cs_active;

  assign cs_valid = (int'(cs_sel_i) < g_num_cs);
  assign half_end = (div_cnt == c_div_max);
  assign last_bit = (bit_cnt == c_bit_max);
  // MISO is taken in the first clk_sys_i cycle of each SCLK high phase.
  assign sample   = (state_q == S_SHIFT) && phase_q && (div_cnt == '0);
  assign sdo_bit  = |(spi_sdo_i & cs_oh_q);

  // Serial frame as it will leave MOSI; the data field is zero on reads.
  always_comb begin
    frame_d = c_frame_len'(addr_i) << g_data_width;
    if (!rw_i) frame_d = frame_d | c_frame_len'(data_i);
    if (g_rw_bit != 0) frame_d[c_frame_len-1] = rw_i;
  end

  always_comb begin
    // NOTE: state_d gets its default before the case so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i && cs_valid) state_d = S_SETUP;
      S_SETUP: if (half_end) state_d = S_SHIFT;
      S_SHIFT: if (half_end && phase_q && last_bit) state_d = S_HOLD;
      S_HOLD:  if (half_end) state_d = S_GAP;
      S_GAP:   if (half_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      // NOTE: non-blocking assignments so every register in this block sees pre-edge values.
      state_q <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      phase_q <= 1'b0;
      rw_q    <= 1'b0;
      cs_oh_q <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      data_o  <= '0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      if (state_q == S_IDLE) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        phase_q <= 1'b0;
        if (start_i) begin
          if (cs_valid) begin
            rw_q    <= rw_i;
            cs_oh_q <= g_num_cs'(1) << cs_sel_i;
            tx_sr   <= frame_d;
          end else begin
            done_o <= 1'b1;
            err_o  <= 1'b1;
          end
        end
      end else begin
        err_o   <= start_i;
        div_cnt <= half_end ? '0 : div_cnt + 1'b1;
        if ((state_q == S_SHIFT) && half_end) begin
          phase_q <= ~phase_q;
          // Leaving the high phase is the SCLK falling edge: advance MOSI.
          if (phase_q) begin
            bit_cnt <= bit_cnt + 1'b1;
            tx_sr   <= tx_sr << 1;
          end
        end
        // Shifting across the whole frame leaves exactly the data field in rx_sr.
        if (sample && rw_q) rx_sr <= (rx_sr << 1) | g_data_width'(sdo_bit);
        if ((state_q == S_GAP) && half_end) begin
          done_o <= 1'b1;
          if (rw_q) data_o <= rx_sr;
        end
      end
    end
  end

  assign cs_active   = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD);
  assign busy_o      = (state_q != S_IDLE);
  assign spi_n_cs_o  = cs_active ? ~cs_oh_q : '1;
  assign spi_sclk_o  = (state_q == S_SHIFT) && phase_q;
  assign spi_sdata_o = ((state_q == S_SETUP) || (state_q == S_SHIFT)) && tx_sr[c_frame_len-1];

endmodule

// File: tb/tb_fmc_spi_master.sv
// Self-checking bench for fmc_spi_master: default build plus a wide-data,
// no-R/W-bit, fastest-SCLK build, each with a behavioural SPI slave.
module tb_fmc_spi_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-parameter instance (L = 17, half-period 2)
  logic        start1, rw1, busy1, done1, err1, sclk1, mosi1;
  logic [2:0]  cs1;
  logic [7:0]  addr1, data1, dout1;
  logic [3:0]  ncs1, sdo1;

  fmc_spi_master u_dut1 (
    .clk_sys_i(clk), .rst_i(rst), .start_i(start1), .rw_i(rw1), .cs_sel_i(cs1),
    .addr_i(addr1), .data_i(data1), .data_o(dout1), .busy_o(busy1), .done_o(done1),
    .err_o(err1), .spi_sclk_o(sclk1), .spi_sdata_o(mosi1), .spi_n_cs_o(ncs1),
    .spi_sdo_i(sdo1)
  );

  // Sweep instance (L = 32, half-period 1, no R/W bit)
  logic        start2, rw2, busy2, done2, err2, sclk2, mosi2;
  logic [2:0]  cs2;
  logic [3:0]  addr2, ncs2, sdo2;
  logic [27:0] data2, dout2;

  fmc_spi_master #(
    .g_num_cs(4), .g_addr_width(4), .g_data_width(28), .g_clk_div(1), .g_rw_bit(0)
  ) u_dut2 (
    .clk_sys_i(clk), .rst_i(rst), .start_i(start2), .rw_i(rw2), .cs_sel_i(cs2),
    .addr_i(addr2), .data_i(data2), .data_o(dout2), .busy_o(busy2), .done_o(done2),
    .err_o(err2), .spi_sclk_o(sclk2), .spi_sdata_o(mosi2), .spi_n_cs_o(ncs2),
    .spi_sdo_i(sdo2)
  );

  // Slaves: present frame bit n after the n-th SCLK falling edge of the frame.
  // The selected line carries the bit, the others carry its complement.
  logic [16:0] slv_vec1 = '0, sh1;
  logic [31:0] slv_vec2 = '0, sh2;
  logic [1:0]  slv_sel1 = '0, slv_sel2 = '0;
  int neg_tot1 = 0, neg_base1 = 0, neg_tot2 = 0, neg_base2 = 0;

  always @(negedge sclk1) neg_tot1 = neg_tot1 + 1;
  always @(negedge sclk2) neg_tot2 = neg_tot2 + 1;
  assign sh1  = slv_vec1 << (neg_tot1 - neg_base1);
  assign sh2  = slv_vec2 << (neg_tot2 - neg_base2);
  assign sdo1 = {4{~sh1[16]}} ^ (4'b0001 << slv_sel1);
  assign sdo2 = {4{~sh2[31]}} ^ (4'b0001 << slv_sel2);

  typedef struct {
    logic        rw;
    logic [2:0]  cs;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [7:0]  slave;
    logic [16:0] exp_mosi;
    logic [3:0]  exp_ncs;
    logic [7:0]  exp_do;
  } vec_t;

  vec_t tbl[4];
  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One full frame on the default instance; inject >= 0 re-pulses start_i at that sample.
  task automatic run1(input vec_t v, input int inject, input string nm);
    logic [16:0] cap = '0;
    logic [8:0]  junk;
    logic [7:0]  do_done = '0;
    logic p_sclk = 1'b0, p_mosi = 1'b0, fin = 1'b0;
    int busy_n = 0, rises = 0, dones = 0, errs = 0, err_at = -1, cs_bad = 0, mosi_bad = 0;
    junk      = 9'($urandom);
    slv_vec1  = {junk, v.slave};
    slv_sel1  = v.cs[1:0];
    neg_base1 = neg_tot1;
    rw1 = v.rw; cs1 = v.cs; addr1 = v.addr; data1 = v.data; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; rw1 = ~v.rw; addr1 = ~v.addr; data1 = ~v.data;
    cs1 = 3'($urandom_range(0, 3));
    for (int k = 0; k < 300 && !fin; k++) begin
      if (busy1) busy_n++;
      if (sclk1 && !p_sclk) begin
        rises++;
        cap = {cap[15:0], mosi1};
      end
      if (sclk1 && p_sclk && (mosi1 !== p_mosi)) mosi_bad++;
      if (busy1 && (ncs1 !== 4'hF) && (ncs1 !== v.exp_ncs)) cs_bad++;
      if (!busy1 && (ncs1 !== 4'hF)) cs_bad++;
      if (err1) begin errs++; err_at = k; end
      if (done1) begin dones++; do_done = dout1; fin = 1'b1; end
      p_sclk = sclk1;
      p_mosi = mosi1;
      start1 = (k == inject);
      if (!fin) @(negedge clk);
    end
    start1 = 1'b0;
    check({nm, " done seen"},     64'(fin),      64'd1);
    check({nm, " mosi frame"},    64'(cap),      64'(v.exp_mosi));
    check({nm, " sclk pulses"},   64'(rises),    64'd17);
    check({nm, " busy cycles"},   64'(busy_n),   64'd74);
    check({nm, " done count"},    64'(dones),    64'd1);
    check({nm, " cs pattern"},    64'(cs_bad),   64'd0);
    check({nm, " mosi stable"},   64'(mosi_bad), 64'd0);
    check({nm, " data_o"},        64'(do_done),  64'(v.exp_do));
    check({nm, " err pulses"},    64'(errs),     (inject >= 0) ? 64'd1 : 64'd0);
    if (inject >= 0) check({nm, " err timing"}, 64'(err_at), 64'(inject + 1));
    @(negedge clk);
    check({nm, " done one cycle"}, 64'(done1), 64'd0);
    check({nm, " data_o held"},    64'(dout1), 64'(v.exp_do));
  endtask

  task automatic bad_cs(input logic [2:0] sel);
    string nm = $sformatf("badcs%0d", sel);
    rw1 = 1'b0; cs1 = sel; addr1 = 8'hAA; data1 = 8'h55; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check({nm, " done"}, 64'(done1), 64'd1);
    check({nm, " err"},  64'(err1),  64'd1);
    check({nm, " busy"}, 64'(busy1), 64'd0);
    check({nm, " ncs"},  64'(ncs1),  64'hF);
    @(negedge clk);
    check({nm, " done cleared"}, 64'(done1), 64'd0);
    check({nm, " err cleared"},  64'(err1),  64'd0);
    check({nm, " ncs idle"},     64'(ncs1),  64'hF);
  endtask

  task automatic reset_mid_shift();
    int rises = 0, late_done = 0, late_busy = 0;
    logic p = 1'b0;
    slv_sel1 = 2'd0; neg_base1 = neg_tot1;
    rw1 = 1'b0; cs1 = 3'd0; addr1 = 8'h33; data1 = 8'h44; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 200 && !(rises == 6 && !sclk1); k++) begin
      if (sclk1 && !p) rises++;
      p = sclk1;
      @(negedge clk);
    end
    check("rst_mid pulses before reset", 64'(rises), 64'd6);
    rst = 1'b1; start1 = 1'b1;
    @(negedge clk);
    check("rst_mid ncs",    64'(ncs1),  64'hF);
    check("rst_mid sclk",   64'(sclk1), 64'd0);
    check("rst_mid mosi",   64'(mosi1), 64'd0);
    check("rst_mid busy",   64'(busy1), 64'd0);
    check("rst_mid done",   64'(done1), 64'd0);
    check("rst_mid data_o", 64'(dout1), 64'd0);
    rst = 1'b0; start1 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done1) late_done++;
      if (busy1) late_busy++;
    end
    check("rst_mid no late done",   64'(late_done), 64'd0);
    check("rst_mid start ignored",  64'(late_busy), 64'd0);
  endtask

  // Frame A (write, cs1) then frame B (read, cs3) requested in A's done cycle.
  task automatic back_to_back(output logic [7:0] rd);
    int dones = 0, busy_n = 0, gap = 0, gap_final = -1;
    logic seen_low = 1'b0;
    logic [7:0] do_b = '0;
    slv_sel1 = 2'd1; slv_vec1 = '0; neg_base1 = neg_tot1;
    rw1 = 1'b0; cs1 = 3'd1; addr1 = 8'h11; data1 = 8'h22; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 400 && dones < 2; k++) begin
      if (busy1) busy_n++;
      if (ncs1 !== 4'hF) begin
        if (seen_low && gap > 0 && gap_final < 0) gap_final = gap;
        seen_low = 1'b1;
      end else if (seen_low && gap_final < 0) begin
        gap++;
      end
      start1 = 1'b0;
      if (done1) begin
        dones++;
        if (dones == 1) begin
          slv_sel1 = 2'd3; slv_vec1 = {9'h1A5, 8'h7E}; neg_base1 = neg_tot1;
          rw1 = 1'b1; cs1 = 3'd3; addr1 = 8'h44; data1 = 8'hFF; start1 = 1'b1;
        end else begin
          do_b = dout1;
        end
      end
      if (dones < 2) @(negedge clk);
    end
    start1 = 1'b0;
    check("b2b done count",  64'(dones),     64'd2);
    check("b2b cs high gap", 64'(gap_final), 64'd3);
    check("b2b busy total",  64'(busy_n),    64'd148);
    check("b2b read data",   64'(do_b),      64'h7E);
    rd = 8'h7E;
    @(negedge clk);
  endtask

  task automatic run2(input logic rw, input logic [1:0] sel, input logic [3:0] a,
                      input logic [27:0] d, input logic [27:0] sv,
                      input logic [27:0] exp_do, input string nm);
    logic [31:0] exp_mosi, cap = '0;
    logic [3:0]  junk, exp_ncs;
    logic [27:0] do_done = '0;
    logic p_sclk = 1'b0, fin = 1'b0;
    int busy_n = 0, rises = 0, dones = 0, errs = 0, cs_bad = 0;
    exp_mosi  = {a, rw ? 28'd0 : d};
    exp_ncs   = ~(4'b0001 << sel);
    junk      = 4'($urandom);
    slv_vec2  = {junk, sv};
    slv_sel2  = sel;
    neg_base2 = neg_tot2;
    rw2 = rw; cs2 = {1'b0, sel}; addr2 = a; data2 = d; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; rw2 = ~rw; addr2 = ~a; data2 = ~d;
    for (int k = 0; k < 200 && !fin; k++) begin
      if (busy2) busy_n++;
      if (sclk2 && !p_sclk) begin
        rises++;
        cap = {cap[30:0], mosi2};
      end
      if (busy2 && (ncs2 !== 4'hF) && (ncs2 !== exp_ncs)) cs_bad++;
      if (err2) errs++;
      if (done2) begin dones++; do_done = dout2; fin = 1'b1; end
      p_sclk = sclk2;
      if (!fin) @(negedge clk);
    end
    check({nm, " done seen"},   64'(fin),     64'd1);
    check({nm, " mosi frame"},  64'(cap),     64'(exp_mosi));
    check({nm, " sclk pulses"}, 64'(rises),   64'd32);
    check({nm, " busy cycles"}, 64'(busy_n),  64'd67);
    check({nm, " cs pattern"},  64'(cs_bad),  64'd0);
    check({nm, " err pulses"},  64'(errs),    64'd0);
    check({nm, " data_o"},      64'(do_done), 64'(exp_do));
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    logic [7:0]  last_rd;
    logic [27:0] last_rd2, rnd_slave;

    tbl[0] = '{1'b0, 3'd1, 8'h5A, 8'hC3, 8'h00, 17'h05AC3, 4'b1101, 8'h00};
    tbl[1] = '{1'b1, 3'd2, 8'h0F, 8'h77, 8'hA5, 17'h10F00, 4'b1011, 8'hA5};
    tbl[2] = '{1'b0, 3'd0, 8'h80, 8'h01, 8'hFF, 17'h08001, 4'b1110, 8'hA5};
    tbl[3] = '{1'b1, 3'd3, 8'hFF, 8'h12, 8'h3C, 17'h1FF00, 4'b0111, 8'h3C};

    rst = 1'b1; start1 = 1'b1; rw1 = 1'b0; cs1 = 3'd0; addr1 = '0; data1 = '0;
    start2 = 1'b0; rw2 = 1'b0; cs2 = 3'd0; addr2 = '0; data2 = '0;
    repeat (3) @(negedge clk);
    check("reset ncs",    64'(ncs1),  64'hF);
    check("reset sclk",   64'(sclk1), 64'd0);
    check("reset mosi",   64'(mosi1), 64'd0);
    check("reset busy",   64'(busy1), 64'd0);
    check("reset done",   64'(done1), 64'd0);
    check("reset err",    64'(err1),  64'd0);
    check("reset data_o", 64'(dout1), 64'd0);
    rst = 1'b0; start1 = 1'b0;
    @(negedge clk);
    check("start during reset ignored", 64'(busy1), 64'd0);

    last_rd = 8'h00;
    for (int i = 0; i < 4; i++) begin
      run1(tbl[i], -1, $sformatf("vec%0d", i));
      last_rd = tbl[i].exp_do;
    end

    v = '{1'b0, 3'd2, 8'h96, 8'h3E, 8'h00, {1'b0, 8'h96, 8'h3E}, 4'b1011, last_rd};
    run1(v, 20, "err_inject");

    bad_cs(3'd5);
    bad_cs(3'd4);

    reset_mid_shift();
    last_rd = 8'h00;
    v = '{1'b1, 3'd0, 8'h21, 8'h00, 8'h96, {1'b1, 8'h21, 8'h00}, 4'b1110, 8'h96};
    run1(v, -1, "after_reset");
    last_rd = v.exp_do;

    back_to_back(last_rd);

    for (int i = 0; i < 10; i++) begin
      v.rw       = 1'($urandom_range(0, 1));
      v.cs       = 3'($urandom_range(0, 3));
      v.addr     = 8'($urandom);
      v.data     = 8'($urandom);
      v.slave    = 8'($urandom);
      v.exp_mosi = {v.rw, v.addr, v.rw ? 8'h00 : v.data};
      v.exp_ncs  = ~(4'b0001 << v.cs);
      v.exp_do   = v.rw ? v.slave : last_rd;
      run1(v, -1, $sformatf("rand%0d", i));
      last_rd = v.exp_do;
    end

    last_rd2 = 28'd0;
    run2(1'b1, 2'd2, 4'h9, 28'h0000000, 28'hA5C3F0E, 28'hA5C3F0E, "sweep_read");
    last_rd2 = 28'hA5C3F0E;
    run2(1'b0, 2'd1, 4'h3, 28'h1234567, 28'h0FFFFFF, last_rd2, "sweep_write");
    rnd_slave = 28'($urandom);
    run2(1'b1, 2'(($urandom_range(0, 3))), 4'($urandom), 28'($urandom), rnd_slave,
         rnd_slave, "sweep_rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fmc_spi_master.md
FMC_SPI_MASTER -- requirements
Module: fmc_spi_master

Interface
REQ-001 Parameter g_num_cs, default 4: number of SPI slaves (1..8), one chip-select and one SDO line each.
REQ-002 Parameter g_addr_width, default 8: register-address field width (1..16).
REQ-003 Parameter g_data_width, default 8: data field width (1..32).
REQ-004 Parameter g_clk_div, default 2: SCLK half-period in clk_sys_i cycles (>=1).
REQ-005 Parameter g_rw_bit, default 1: 1 = frame starts with R/W bit (1=read), 0 = no R/W bit.
REQ-006 clk_sys_i  in  1  single clock; all logic rising-edge.
REQ-007 rst_i  in  1  synchronous, active-high reset.
REQ-008 start_i  in  1  request pulse; sampled only in IDLE.
REQ-009 rw_i  in  1  1 = read, 0 = write.
REQ-010 cs_sel_i  in  3  target slave index.
REQ-011 addr_i  in  g_addr_width  register address.
REQ-012 data_i  in  g_data_width  write data.
REQ-013 data_o  out  g_data_width  last read data.
REQ-014 busy_o  out  1  transaction in progress.
REQ-015 done_o  out  1  one-cycle completion pulse.
REQ-016 err_o  out  1  one-cycle error pulse.
REQ-017 spi_sclk_o  out  1  shared SCLK, idle low.
REQ-018 spi_sdata_o  out  1  shared MOSI.
REQ-019 spi_n_cs_o  out  g_num_cs  active-low chip selects.
REQ-020 spi_sdo_i  in  g_num_cs  per-slave MISO.

Function
REQ-021 Frame length L = g_rw_bit + g_addr_width + g_data_width; order: R/W bit, address MSB-first, data MSB-first.
REQ-022 States: IDLE, SETUP, SHIFT, HOLD, GAP; IDLE->SETUP on accepted start_i.
REQ-023 Acceptance: start_i=1 in IDLE with cs_sel_i < g_num_cs; rw_i, cs_sel_i, addr_i, data_i captured that cycle; later input changes ignored until next IDLE.
REQ-024 busy_o high from cycle after acceptance through last GAP cycle; busy length exactly g_clk_div*(2L+3) cycles.
REQ-025 SETUP: selected spi_n_cs_o bit low, SCLK low, MOSI = first frame bit, g_clk_div cycles.
REQ-026 SHIFT: L SCLK periods, each g_clk_div cycles low then g_clk_div high; MOSI changes only on SCLK falling edge.
REQ-027 Read: during data field MOSI = 0; selected spi_sdo_i sampled on the clk_sys_i cycle of each SCLK rising edge, shifted in MSB-first.
REQ-028 Write: data field driven from captured data_i; spi_sdo_i ignored; data_o unchanged.
REQ-029 HOLD: SCLK low, CS still low, g_clk_div cycles; GAP: all CS high, MOSI 0, g_clk_div cycles, then IDLE.
REQ-030 done_o pulses in first IDLE cycle after GAP; on reads data_o updates same cycle and holds until next completed read.
REQ-031 start_i while busy_o=1: ignored, err_o pulses next cycle, transaction in progress unaffected.
REQ-032 start_i in IDLE with cs_sel_i >= g_num_cs: no CS asserted, busy_o stays 0, done_o and err_o pulse together next cycle.
REQ-033 Back-to-back: start_i in the done_o cycle is accepted (IDLE); minimum CS-high gap = g_clk_div+1 cycles.
REQ-034 Never more than one spi_n_cs_o bit low.

Reset
REQ-035 rst_i=1 at a clock edge forces next cycle: IDLE, spi_n_cs_o all ones, spi_sclk_o 0, spi_sdata_o 0, busy_o 0, done_o 0, err_o 0, data_o 0.
REQ-036 Reset mid-transaction aborts immediately, no done_o; start_i in the cycle rst_i is high is ignored.

Verification
REQ-037 Write: defaults, cs_sel_i=1, addr_i=0x5A, data_i=0xC3 -> spi_n_cs_o=4'b1101, MOSI bits 0,01011010,11000011, 17 SCLK pulses, busy 74 cycles, one done_o, data_o=0.
REQ-038 Read: cs_sel_i=2, addr_i=0x0F, spi_sdo_i[2] drives 0xA5 on data field -> MOSI 1,00001111,00000000, data_o=0xA5 at done_o.
REQ-039 Errors: start_i mid-transaction -> err_o 1 cycle, frame unchanged; cs_sel_i=5 in IDLE -> done_o+err_o, no CS low.
REQ-040 Reset mid-SHIFT (after 6 SCLK pulses) -> next cycle all CS high, SCLK 0, busy_o 0, no done_o; next start_i runs full frame.
REQ-041 Parameter sweep: g_rw_bit=0, g_addr_width=4, g_data_width=28, g_clk_div=1 -> 32 SCLK pulses, busy 67 cycles, read data MSB-first correct.
REQ-042 Back-to-back: start_i in done_o cycle -> second frame accepted, CS high exactly g_clk_div+1 cycles between frames.
